// File: rtl/decode_scan.sv
// 3-to-8 decoder with a manual/auto-scan index source, driving one-hot LEDs
// and a single active-low 7-segment digit.
module decode_scan #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       dir,
  input  logic [2:0] sel,
  output logic [7:0] led,
  output logic [6:0] seg0,
  output logic       valid,
  output logic       wrap
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  state_t          st;
  state_t          st_next;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;
  logic            tick;

  // Active-low segment pattern for one octal digit, bit0=a .. bit6=g.
  function automatic logic [6:0] digit(input logic [2:0] d);
    case (d)
      3'd0:    digit = 7'b1000000;
      3'd1:    digit = 7'b1111001;
      3'd2:    digit = 7'b0100100;
      3'd3:    digit = 7'b0110000;
      3'd4:    digit = 7'b0011001;
      3'd5:    digit = 7'b0010010;
      3'd6:    digit = 7'b0000010;
      default: digit = 7'b1111000;
    endcase
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_next;
  end

  // Next-state logic: the target state follows en/mode directly every edge.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    st_next = IDLE;
    if (en) st_next = mode ? AUTO : MANUAL;
  end

  // A tick only counts while already scanning and staying in AUTO, so a
  // pending tick is dropped on exit and entry always restarts the prescaler.
  assign tick = (st == AUTO) && (st_next == AUTO) && (cnt == CNT_LAST);

  // Index, prescaler and wrap datapath, keyed on the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= 3'd0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= '0;
      wrap <= 1'b0;
      case (st_next)
        MANUAL: idx <= sel;
        AUTO: begin
          if (st == AUTO) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
              idx  <= dir ? idx - 3'd1 : idx + 3'd1;
              wrap <= dir ? (idx == 3'd0) : (idx == 3'd7);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state and index.
  always_comb begin
    valid = (st != IDLE);
    led   = 8'h00;
    seg0  = 7'h7F;
    if (valid) begin
      led  = 8'b1 << idx;
      seg0 = digit(idx);
    end
  end

endmodule

// File: tb/tb_decode_scan.sv
// Directed bench for decode_scan (TICK_DIV=4): the driver queues hand-computed
// expectations, an independent monitor compares them after each clock edge.
module tb_decode_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       mode = 1'b1;
  logic       dir = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] led;
  logic [6:0] seg0;
  logic       valid;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [7:0] led;
    logic [6:0] seg;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];

  decode_scan #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .dir   (dir),
    .sel   (sel),
    .led   (led),
    .seg0  (seg0),
    .valid (valid),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  // Hand-copied digit table for the expected segment patterns.
  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  // Expected index/wrap per edge, counted from the AUTO entry edge.
  int t3_idx [10] = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0};
  int t3_wr  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t4_idx [14] = '{1, 1, 1, 1, 0, 0, 0, 0, 7, 7, 7, 7, 0, 0};
  int t4_wr  [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  int t5_idx [5]  = '{0, 0, 1, 1, 1};

  // Drive one cycle of inputs; optionally queue what the DUT must show after
  // the coming rising edge.
  task automatic cyc(input logic r, input logic e, input logic m, input logic d,
                     input logic [2:0] s, input bit chk, input bit ev,
                     input int ei, input bit ew, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; dir = d; sel = s;
    if (chk) begin
      x.name  = nm;
      x.valid = ev;
      x.wrap  = ew;
      x.led   = ev ? (8'b1 << ei) : 8'h00;
      x.seg   = ev ? seg_tab[ei] : 7'h7F;
      exp_q.push_back(x);
    end
    @(posedge clk);
  endtask

  // Monitor: compare after every edge that has a queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        tests++;
        if (led !== x.led || seg0 !== x.seg || valid !== x.valid || wrap !== x.wrap) begin
          fails++;
          $display("FAIL %s: got led=%h seg0=%b valid=%b wrap=%b, expected led=%h seg0=%b valid=%b wrap=%b",
                   x.name, led, seg0, valid, wrap, x.led, x.seg, x.valid, x.wrap);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset held with en=1, mode=1 keeps everything blank.
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 3'd4, 1, 0, 0, 0, "rst_hold");

    // T2: manual index with one-cycle latency.
    cyc(0, 1, 0, 0, 3'd5, 1, 1, 5, 0, "man_sel5");
    cyc(0, 1, 0, 0, 3'd0, 1, 1, 0, 0, "man_sel0");

    // T3: auto up from 6, wrapping 7->0.
    cyc(0, 1, 0, 0, 3'd6, 1, 1, 6, 0, "man_sel6");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 1, 0, 3'd2, 1, 1, t3_idx[i], t3_wr[i][0], $sformatf("auto_up_%0d", i));

    // T4: auto down from 1, then flip to up mid-period.
    cyc(0, 1, 0, 0, 3'd1, 1, 1, 1, 0, "man_sel1");
    for (int i = 0; i < 14; i++)
      cyc(0, 1, 1, (i < 10) ? 1'b1 : 1'b0, 3'd5, 1, 1, t4_idx[i], t4_wr[i][0],
          $sformatf("auto_dn_flip_%0d", i));

    // T5: continue scanning, disable at cnt=2, re-enable from the held index.
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 1, 0, 3'd7, 1, 1, t5_idx[i], 0, $sformatf("auto_pre_dis_%0d", i));
    cyc(0, 0, 1, 0, 3'd7, 1, 0, 0, 0, "disabled_0");
    cyc(0, 0, 0, 0, 3'd7, 1, 0, 0, 0, "disabled_1");
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 1, 0, 3'd7, 1, 1, 1, 0, $sformatf("reenable_hold_%0d", i));
    cyc(0, 1, 1, 0, 3'd7, 1, 1, 2, 0, "reenable_step");

    // T6: reset mid-scan at idx=3 clears idx and blanks the outputs.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 3'd6, 1, 1, 2, 0, $sformatf("pre_rst_%0d", i));
    cyc(0, 1, 1, 0, 3'd6, 1, 1, 3, 0, "pre_rst_idx3");
    cyc(1, 1, 1, 0, 3'd6, 1, 0, 0, 0, "rst_mid_scan");
    cyc(0, 1, 1, 0, 3'd6, 1, 1, 0, 0, "post_rst_idx0");

    cyc(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "drain");
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
